pn_frame_ctrl: RTL and testbench

Frame sequencer for the PSK transmit bit path. On `start`, it emits one frame as a single bit stream:
- a PN preamble of PRE_REPS full periods of the 5-bit LFSR sequence,
- then payload_len payload bits passed through from upstream,
- then GUARD_LEN zero bits.

It owns the PN LFSR, reseeding and advancing it only on accepted preamble beats. The serial output feeds the modulator mapper over a valid/ready handshake.

---
 rtl/pn_pkg.sv | 27 ++
 rtl/pn_lfsr5.sv | 27 ++
 rtl/pn_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_pn_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared constants and types for the PN preamble frame sequencer.
package pn_pkg;

    localparam logic [4:0] PN_SEED   = 5'b00001;
    localparam int         PN_PERIOD = 31;
    localparam int         PN_TAP_HI = 4;
    localparam int         PN_TAP_LO = 2;

    typedef enum logic [1:0] {
        PH_NONE  = 2'd0,
        PH_PRE   = 2'd1,
        PH_PAY   = 2'd2,
        PH_GUARD = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAY,
        ST_GUARD
    } state_t;

    function automatic logic [4:0] pn_next(input logic [4:0] s);
        return {s[3:0], s[PN_TAP_HI] ^ s[PN_TAP_LO]};
    endfunction

endpackage

// File: rtl/pn_lfsr5.sv
// 5-bit maximal-length PN generator with explicit seed load and lock-up recovery.
module pn_lfsr5
    import pn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic pn_bit
);

    logic [4:0] s;

    // NOTE: sequential state uses <= only, so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= PN_SEED;
        end else if (load || s == 5'b00000) begin
            s <= PN_SEED;
        end else if (adv) begin
            s <= pn_next(s);
        end
    end

    assign pn_bit = s[PN_TAP_HI];

endmodule

// File: rtl/pn_frame_ctrl.sv
// Frame sequencer: PN preamble, pass-through payload, zero guard, one registered output beat.
module pn_frame_ctrl
    import pn_pkg::*;
#(
    parameter int PRE_REPS  = 2,
    parameter int GUARD_LEN = 8,
    parameter int LEN_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             m_bit,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       m_phase,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam int PRE_TOTAL = PN_PERIOD * PRE_REPS;
    localparam int PRE_W     = $clog2(PRE_TOTAL);
    localparam int GUARD_W   = $clog2(GUARD_LEN + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PRE_TOTAL - 1);
    localparam logic [GUARD_W-1:0] GUARD_END  = GUARD_W'(GUARD_LEN);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_LEN - 1);

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_q;
    logic [PRE_W-1:0]   pre_cnt;
    logic [LEN_W-1:0]   pay_cnt;
    logic [GUARD_W-1:0] guard_cnt;

    logic   pn_bit;
    logic   lfsr_load, lfsr_adv;
    logic   load_ok, load_beat, bit_avail, pay_left;
    logic   bit_n, last_n, done_n;
    phase_t phase_n;

    pn_lfsr5 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .adv    (lfsr_adv),
        .pn_bit (pn_bit)
    );

    // The output stage can take a new beat when empty or when its beat leaves this cycle.
    assign load_ok   = !m_valid || m_ready;
    assign pay_left  = (pay_cnt != len_q);
    assign load_beat = bit_avail && load_ok;
    assign s_ready   = (state == ST_PAY) && pay_left && load_ok;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n   = state;
        bit_avail = 1'b0;
        bit_n     = 1'b0;
        phase_n   = PH_NONE;
        last_n    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        done_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_PRE;
                    lfsr_load = 1'b1;
                end
            end
            ST_PRE: begin
                bit_avail = 1'b1;
                bit_n     = pn_bit;
                phase_n   = PH_PRE;
                if (load_ok) begin
                    lfsr_adv = 1'b1;
                    if (pre_cnt == PRE_LAST)
                        state_n = (len_q == '0) ? ST_GUARD : ST_PAY;
                end
            end
            ST_PAY: begin
                bit_avail = s_valid && pay_left;
                bit_n     = s_data;
                phase_n   = PH_PAY;
                if (load_beat && pay_cnt == len_q - LEN_W'(1))
                    state_n = ST_GUARD;
            end
            ST_GUARD: begin
                bit_avail = (guard_cnt != GUARD_END);
                phase_n   = PH_GUARD;
                last_n    = (guard_cnt == GUARD_LAST);
                // Leave only once the final guard beat has actually been taken downstream.
                if (m_valid && m_ready && m_last) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            pre_cnt   <= '0;
            pay_cnt   <= '0;
            guard_cnt <= '0;
            m_bit     <= 1'b0;
            m_phase   <= PH_NONE;
            m_last    <= 1'b0;
            m_valid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_n;
            if (state == ST_IDLE && start) begin
                len_q     <= payload_len;
                pre_cnt   <= '0;
                pay_cnt   <= '0;
                guard_cnt <= '0;
            end
            if (load_beat) begin
                m_valid <= 1'b1;
                m_bit   <= bit_n;
                m_phase <= phase_n;
                m_last  <= last_n;
                case (state)
                    ST_PRE:   pre_cnt   <= pre_cnt + PRE_W'(1);
                    ST_PAY:   pay_cnt   <= pay_cnt + LEN_W'(1);
                    ST_GUARD: guard_cnt <= guard_cnt + GUARD_W'(1);
                    default:  ;
                endcase
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pn_frame_ctrl.sv
// Directed and randomized checks of pn_frame_ctrl against a sequence-level frame model.
module tb_pn_frame_ctrl;

    localparam int LEN_W = 12;
    localparam int GUARD = 8;
    localparam int PRE_A = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: PRE_REPS=1
    logic             rst = 1'b0, start = 1'b0, s_data = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [LEN_W-1:0] payload_len = '0;
    logic             s_ready, m_bit, m_valid, m_last, busy, done;
    logic [1:0]       m_phase;

    // DUT B: PRE_REPS=2
    logic             b_start = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
    logic [LEN_W-1:0] b_len = '0;
    logic             b_s_ready, b_m_bit, b_m_valid, b_m_last, b_busy, b_done;
    logic [1:0]       b_m_phase;

    pn_frame_ctrl #(.PRE_REPS(1), .GUARD_LEN(GUARD), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .payload_len(payload_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_bit(m_bit), .m_valid(m_valid), .m_ready(m_ready), .m_phase(m_phase),
        .m_last(m_last), .busy(busy), .done(done)
    );

    pn_frame_ctrl #(.PRE_REPS(2), .GUARD_LEN(GUARD), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .payload_len(b_len),
        .s_data(1'b0), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_bit(b_m_bit), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_phase(b_m_phase),
        .m_last(b_m_last), .busy(b_busy), .done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic       q_bit[$];
    logic [1:0] q_ph[$];
    logic       q_last[$];
    logic       e_bit[$];
    logic [1:0] e_ph[$];
    logic       e_last[$];
    logic       pay_data[$];

    int first_valid_cyc, last_cyc, done_cyc, n_bubble, hold_errs, pidx;
    int done_after_rst, valid_after_rst;
    logic busy_at1, busy_at_done, sready_seen;
    logic post_rst_valid, post_rst_busy, post_rst_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected frame from the sequence rule x[n] = x[n-5] ^ x[n-3], seeded x[0..4] = 0,0,0,0,1.
    task automatic build_exp(input int reps, input int len);
        logic x[$];
        e_bit.delete(); e_ph.delete(); e_last.delete();
        for (int n = 0; n < 31; n++)
            x.push_back(n < 5 ? (n == 4) : (x[n-5] ^ x[n-3]));
        for (int r = 0; r < reps; r++)
            for (int n = 0; n < 31; n++) begin
                e_bit.push_back(x[n]); e_ph.push_back(2'd1); e_last.push_back(1'b0);
            end
        for (int i = 0; i < len; i++) begin
            e_bit.push_back(pay_data[i]); e_ph.push_back(2'd2); e_last.push_back(1'b0);
        end
        for (int g = 0; g < GUARD; g++) begin
            e_bit.push_back(1'b0); e_ph.push_back(2'd3); e_last.push_back(g == GUARD - 1);
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, " n_beats"}, q_bit.size(), e_bit.size());
        n = (q_bit.size() < e_bit.size()) ? q_bit.size() : e_bit.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s beat%0d {bit,phase,last}", tag, i),
                  {q_bit[i], q_ph[i], q_last[i]}, {e_bit[i], e_ph[i], e_last[i]});
    endtask

    task automatic run_frame(input int len, input logic rand_ready, input logic rand_valid,
                             input int gap_at, input logic restart_pay, input int rst_beat);
        int   gap_left = 0;
        logic gap_done = 1'b0;
        logic stall_prev = 1'b0;
        logic [3:0] held = '0;
        q_bit.delete(); q_ph.delete(); q_last.delete();
        first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
        n_bubble = 0; hold_errs = 0; pidx = 0; sready_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; payload_len = LEN_W'(len); s_valid = 1'b0; m_ready = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start       = 1'b0;
            payload_len = LEN_W'(len);
            m_ready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gap_at >= 0 && !gap_done && pidx == gap_at) begin
                gap_left = 5; gap_done = 1'b1;
            end
            s_valid = (gap_left > 0) ? 1'b0 : (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (gap_left > 0) gap_left--;
            s_data = (pidx < len) ? pay_data[pidx] : 1'b0;
            if (restart_pay && q_bit.size() == PRE_A + 1) begin
                start = 1'b1; payload_len = LEN_W'(len + 7);
            end
            #1;
            if (cyc == 1) busy_at1 = busy;
            if (stall_prev && {m_valid, m_bit, m_phase, m_last} !== {1'b1, held}) hold_errs++;
            stall_prev = m_valid && !m_ready;
            held = {m_bit, m_phase, m_last};
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (first_valid_cyc >= 0 && last_cyc < 0 && !m_valid) n_bubble++;
            if (s_ready) sready_seen = 1'b1;
            if (s_valid && s_ready) pidx++;
            if (done) begin
                done_cyc = cyc; busy_at_done = busy;
                break;
            end
            if (m_valid && m_ready) begin
                q_bit.push_back(m_bit); q_ph.push_back(m_phase); q_last.push_back(m_last);
                if (m_last) last_cyc = cyc;
            end
            if (rst_beat >= 0 && q_bit.size() == PRE_A + rst_beat) begin
                rst = 1'b1;
                @(negedge clk); #1;
                post_rst_valid = m_valid; post_rst_busy = busy; post_rst_done = done;
                rst = 1'b0; start = 1'b0;
                done_after_rst = 0; valid_after_rst = 0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk); #1;
                    if (done) done_after_rst++;
                    if (m_valid) valid_after_rst++;
                end
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pre8;
        logic [3:0] pay4;
        int ones, rep_mis, ph1, ph2_cnt, rlen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs A", {m_valid, m_bit, m_phase, m_last, busy, done, s_ready}, 0);
        check("reset outputs B", {b_m_valid, b_m_bit, b_m_phase, b_m_last, b_busy, b_done, b_s_ready}, 0);
        rst = 1'b0;

        // 1: basic frame, len=4, data 1,0,1,1
        pay4 = 4'b1011;
        pay_data.delete();
        for (int i = 0; i < 4; i++) pay_data.push_back(pay4[3-i]);
        run_frame(4, 1'b0, 1'b0, -1, 1'b0, -1);
        build_exp(1, 4);
        compare_frame("t1");
        check("t1 first m_valid cycle", first_valid_cyc, 2);
        check("t1 busy after start", busy_at1, 1);
        check("t1 done seen", done_cyc >= 0, 1);
        check("t1 done after last", done_cyc, last_cyc + 1);
        check("t1 busy at done", busy_at_done, 0);
        check("t1 bubbles", n_bubble, 0);
        pre8 = 8'b0000_1001;
        for (int i = 0; i < 8; i++)
            if (q_bit.size() > i) check($sformatf("t1 pre bit%0d", i), q_bit[i], pre8[7-i]);
        if (q_last.size() == 43) check("t1 m_last on beat 42", q_last[42], 1);
        @(negedge clk); #1;
        check("t1 done single pulse", done, 0);
        check("t1 idle m_valid", m_valid, 0);

        // 2: PRE_REPS=2 on DUT B
        q_bit.delete(); q_ph.delete(); q_last.delete();
        pay_data.delete();
        b_len = '0; b_s_valid = 1'b1; b_m_ready = 1'b1;
        @(negedge clk); b_start = 1'b1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk); b_start = 1'b0; #1;
            if (b_done) begin done_cyc = cyc; break; end
            if (b_m_valid) begin
                q_bit.push_back(b_m_bit); q_ph.push_back(b_m_phase); q_last.push_back(b_m_last);
            end
        end
        check("t2 done seen", done_cyc >= 0, 1);
        build_exp(2, 0);
        compare_frame("t2");
        ones = 0; rep_mis = 0; ph1 = 0;
        if (q_bit.size() >= 62) begin
            for (int i = 0; i < 31; i++) begin
                ones += int'(q_bit[i]);
                if (q_bit[i] !== q_bit[i+31]) rep_mis++;
            end
            for (int i = 0; i < 62; i++) if (q_ph[i] == 2'd1) ph1++;
        end
        check("t2 ones in period", ones, 16);
        check("t2 period repeat mismatches", rep_mis, 0);
        check("t2 phase=1 beats", ph1, 62);

        // 3: random m_ready, same frame as test 1
        pay_data.delete();
        for (int i = 0; i < 4; i++) pay_data.push_back(pay4[3-i]);
        run_frame(4, 1'b1, 1'b0, -1, 1'b0, -1);
        build_exp(1, 4);
        compare_frame("t3");
        check("t3 hold violations", hold_errs, 0);
        check("t3 done seen", done_cyc >= 0, 1);

        // Randomized frame: random length, data, m_ready and s_valid
        rlen = int'($urandom_range(1, 16));
        pay_data.delete();
        for (int i = 0; i < rlen; i++) pay_data.push_back(1'($urandom_range(0, 1)));
        run_frame(rlen, 1'b1, 1'b1, -1, 1'b0, -1);
        build_exp(1, rlen);
        compare_frame("trand");
        check("trand hold violations", hold_errs, 0);
        check("trand done seen", done_cyc >= 0, 1);

        // 4: zero-length payload
        pay_data.delete();
        run_frame(0, 1'b0, 1'b1, -1, 1'b0, -1);
        build_exp(1, 0);
        compare_frame("t4");
        check("t4 s_ready seen", sready_seen, 0);
        ph2_cnt = 0;
        foreach (q_ph[i]) if (q_ph[i] == 2'd2) ph2_cnt++;
        check("t4 payload phase beats", ph2_cnt, 0);
        if (q_ph.size() == 39) check("t4 phase 1->3", {q_ph[30], q_ph[31]}, {2'd1, 2'd3});

        // 5: s_valid gap mid-payload plus ignored restart
        pay_data.delete();
        for (int i = 0; i < 6; i++) pay_data.push_back(1'($urandom_range(0, 1)));
        run_frame(6, 1'b0, 1'b0, 2, 1'b1, -1);
        build_exp(1, 6);
        compare_frame("t5");
        check("t5 bubble cycles", n_bubble, 5);
        check("t5 done seen", done_cyc >= 0, 1);

        // 6: reset at payload beat 2, then replay
        pay_data.delete();
        for (int i = 0; i < 5; i++) pay_data.push_back(1'b1);
        run_frame(5, 1'b0, 1'b0, -1, 1'b0, 2);
        check("t6 m_valid after rst", post_rst_valid, 0);
        check("t6 busy after rst", post_rst_busy, 0);
        check("t6 done after rst", post_rst_done, 0);
        check("t6 later done pulses", done_after_rst, 0);
        check("t6 later m_valid cycles", valid_after_rst, 0);
        pay_data.delete();
        for (int i = 0; i < 3; i++) pay_data.push_back(1'($urandom_range(0, 1)));
        run_frame(3, 1'b0, 1'b0, -1, 1'b0, -1);
        build_exp(1, 3);
        compare_frame("t6 replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
